// File: rtl/instruction_decode_pkg.sv
// Shared decode constants for the ID stage: opcodes, function codes,
// the link register index and the internal control bundle.
package instruction_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LB    = 6'd32;
  localparam logic [5:0] OP_LH    = 6'd33;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_LBU   = 6'd36;
  localparam logic [5:0] OP_LHU   = 6'd37;
  localparam logic [5:0] OP_LWU   = 6'd39;
  localparam logic [5:0] OP_SB    = 6'd40;
  localparam logic [5:0] OP_SH    = 6'd41;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FUNCT_JR   = 6'd8;
  localparam logic [5:0] FUNCT_JALR = 6'd9;

  localparam logic [4:0] LINK_REG = 5'd31;

  // Control bundle produced by the opcode decoder; reads_rt and zero_ext
  // stay inside the stage (hazard detection and immediate extension).
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [4:0] wr_addr;
    logic       reads_rt;
    logic       zero_ext;
  } ctrl_t;

  // Number of bits needed to represent value (clogb2(31) = 5).
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// Register file: two combinational read ports with write-through from the
// write port, one write port, register 0 hardwired to zero.
module register_file
  import instruction_decode_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int N_REGS  = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_write,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr_a,
  output logic [NB_DATA-1:0] o_rd_data_a,
  input  logic [NB_ADDR-1:0] i_rd_addr_b,
  output logic [NB_DATA-1:0] o_rd_data_b
);

  logic [NB_DATA-1:0] regs [N_REGS];
  logic               wr_en;

  assign wr_en = i_write && (i_wr_addr != '0);

  // Storage: cleared on reset, written on the clock edge unless the target is r0.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Read ports: r0 reads zero, a same-cycle write to the read address wins.
  always_comb begin
    o_rd_data_a = regs[i_rd_addr_a];
    o_rd_data_b = regs[i_rd_addr_b];
    if (i_rd_addr_a == '0) begin
      o_rd_data_a = '0;
    end else if (wr_en && (i_wr_addr == i_rd_addr_a)) begin
      o_rd_data_a = i_wr_data;
    end
    if (i_rd_addr_b == '0) begin
      o_rd_data_b = '0;
    end else if (wr_en && (i_wr_addr == i_rd_addr_b)) begin
      o_rd_data_b = i_wr_data;
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: field/control decode, early branch and jump resolution,
// load-use stall detection and the ID/EX pipeline register.
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int NB_REG   = 32,
  parameter int NB_INSTR = 32,
  parameter int N_REGS   = 32,
  localparam int NB_ADDR = clogb2(N_REGS - 1)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [NB_INSTR-1:0] i_instruction,
  input  logic [NB_REG-1:0]   i_pc,
  input  logic                i_wb_write,
  input  logic [NB_ADDR-1:0]  i_wb_addr,
  input  logic [NB_REG-1:0]   i_wb_data,
  input  logic                i_ex_mem_read,
  input  logic [NB_ADDR-1:0]  i_ex_rt,
  output logic                o_branch,
  output logic                o_jump_inm,
  output logic                o_jump_rs,
  output logic [15:0]         o_inm_i,
  output logic [25:0]         o_inm_j,
  output logic [NB_REG-1:0]   o_rs_jump,
  output logic                o_nop_reg,
  output logic                o_stall,
  output logic [NB_REG-1:0]   o_rs_data,
  output logic [NB_REG-1:0]   o_rt_data,
  output logic [NB_REG-1:0]   o_inm_ext,
  output logic [NB_REG-1:0]   o_pc,
  output logic [NB_ADDR-1:0]  o_rs_addr,
  output logic [NB_ADDR-1:0]  o_rt_addr,
  output logic [NB_ADDR-1:0]  o_wr_addr,
  output logic [5:0]          o_opcode,
  output logic [5:0]          o_funct,
  output logic                o_reg_write,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_mem_to_reg,
  output logic                o_alu_src
);

  logic [NB_INSTR-1:0] instr;
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic [NB_ADDR-1:0]  rs;
  logic [NB_ADDR-1:0]  rt;
  logic [NB_ADDR-1:0]  rd;
  logic [15:0]         imm;
  logic [NB_REG-1:0]   imm_ext;
  logic [NB_REG-1:0]   rs_data;
  logic [NB_REG-1:0]   rt_data;
  ctrl_t               ctrl;
  logic                branch_raw;
  logic                jump_inm_raw;
  logic                jump_rs_raw;
  logic                redirect_ok;
  logic                any_redirect;

  // A squashed slot is decoded as the all-zero NOP instruction.
  assign instr  = o_nop_reg ? '0 : i_instruction;
  assign opcode = instr[31:26];
  assign rs     = instr[21 +: NB_ADDR];
  assign rt     = instr[16 +: NB_ADDR];
  assign rd     = instr[11 +: NB_ADDR];
  assign imm    = instr[15:0];
  assign funct  = instr[5:0];

  assign o_inm_i = i_instruction[15:0];
  assign o_inm_j = i_instruction[25:0];

  register_file #(
    .NB_DATA (NB_REG),
    .N_REGS  (N_REGS),
    .NB_ADDR (NB_ADDR)
  ) u_register_file (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_write     (i_wb_write),
    .i_wr_addr   (i_wb_addr),
    .i_wr_data   (i_wb_data),
    .i_rd_addr_a (rs),
    .o_rd_data_a (rs_data),
    .i_rd_addr_b (rt),
    .o_rd_data_b (rt_data)
  );

  // Opcode to control decode; anything unrecognised stays an all-zero NOP.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        if (instr != '0) begin
          ctrl.reads_rt = 1'b1;
          if (funct != FUNCT_JR) begin
            ctrl.reg_write = 1'b1;
            ctrl.wr_addr   = rd;
          end
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wr_addr   = rt;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wr_addr   = rt;
        ctrl.zero_ext  = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.wr_addr    = rt;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.reads_rt  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.reads_rt = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.wr_addr   = LINK_REG;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

  assign imm_ext = ctrl.zero_ext ? {{(NB_REG-16){1'b0}}, imm}
                                 : {{(NB_REG-16){imm[15]}}, imm};

  // Load-use hazard: the load in EX targets a register this instruction reads.
  always_comb begin
    o_stall = 1'b0;
    if (!i_reset && i_ex_mem_read && (i_ex_rt != '0)) begin
      o_stall = (i_ex_rt == rs) || (ctrl.reads_rt && (i_ex_rt == rt));
    end
  end

  // Early redirect resolution, suppressed while stalling or squashing.
  always_comb begin
    branch_raw   = ((opcode == OP_BEQ) && (rs_data == rt_data)) ||
                   ((opcode == OP_BNE) && (rs_data != rt_data));
    jump_inm_raw = (opcode == OP_J) || (opcode == OP_JAL);
    jump_rs_raw  = (opcode == OP_RTYPE) &&
                   ((funct == FUNCT_JR) || (funct == FUNCT_JALR));
    redirect_ok  = !i_reset && !o_stall && !o_nop_reg;
    o_branch     = redirect_ok && branch_raw;
    o_jump_inm   = redirect_ok && jump_inm_raw;
    o_jump_rs    = redirect_ok && jump_rs_raw;
    any_redirect = o_branch || o_jump_inm || o_jump_rs;
  end

  assign o_rs_jump = rs_data;

  // ID/EX register: capture on valid, bubble on stall or squash, hold otherwise.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_rs_data    <= '0;
      o_rt_data    <= '0;
      o_inm_ext    <= '0;
      o_pc         <= '0;
      o_rs_addr    <= '0;
      o_rt_addr    <= '0;
      o_wr_addr    <= '0;
      o_opcode     <= '0;
      o_funct      <= '0;
      o_reg_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_alu_src    <= 1'b0;
      o_nop_reg    <= 1'b0;
    end else if (i_valid) begin
      o_nop_reg <= any_redirect;
      if (o_stall || o_nop_reg) begin
        o_rs_data    <= '0;
        o_rt_data    <= '0;
        o_inm_ext    <= '0;
        o_pc         <= '0;
        o_rs_addr    <= '0;
        o_rt_addr    <= '0;
        o_wr_addr    <= '0;
        o_opcode     <= '0;
        o_funct      <= '0;
        o_reg_write  <= 1'b0;
        o_mem_read   <= 1'b0;
        o_mem_write  <= 1'b0;
        o_mem_to_reg <= 1'b0;
        o_alu_src    <= 1'b0;
      end else begin
        o_rs_data    <= rs_data;
        o_rt_data    <= rt_data;
        o_inm_ext    <= imm_ext;
        o_pc         <= i_pc;
        o_rs_addr    <= rs;
        o_rt_addr    <= rt;
        o_wr_addr    <= ctrl.wr_addr;
        o_opcode     <= opcode;
        o_funct      <= funct;
        o_reg_write  <= ctrl.reg_write;
        o_mem_read   <= ctrl.mem_read;
        o_mem_write  <= ctrl.mem_write;
        o_mem_to_reg <= ctrl.mem_to_reg;
        o_alu_src    <= ctrl.alu_src;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed, table-driven bench for the ID stage plus hand sequences for
// hold, asynchronous reset mid-stall and reset mid-squash.
module tb_instruction_decode;

  logic        i_clock;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_instruction;
  logic [31:0] i_pc;
  logic        i_wb_write;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_ex_mem_read;
  logic [4:0]  i_ex_rt;
  logic        o_branch, o_jump_inm, o_jump_rs;
  logic [15:0] o_inm_i;
  logic [25:0] o_inm_j;
  logic [31:0] o_rs_jump;
  logic        o_nop_reg, o_stall;
  logic [31:0] o_rs_data, o_rt_data, o_inm_ext, o_pc;
  logic [4:0]  o_rs_addr, o_rt_addr, o_wr_addr;
  logic [5:0]  o_opcode, o_funct;
  logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src;

  int testCount = 0;
  int failCount = 0;

  instruction_decode dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_instruction (i_instruction),
    .i_pc          (i_pc),
    .i_wb_write    (i_wb_write),
    .i_wb_addr     (i_wb_addr),
    .i_wb_data     (i_wb_data),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rt       (i_ex_rt),
    .o_branch      (o_branch),
    .o_jump_inm    (o_jump_inm),
    .o_jump_rs     (o_jump_rs),
    .o_inm_i       (o_inm_i),
    .o_inm_j       (o_inm_j),
    .o_rs_jump     (o_rs_jump),
    .o_nop_reg     (o_nop_reg),
    .o_stall       (o_stall),
    .o_rs_data     (o_rs_data),
    .o_rt_data     (o_rt_data),
    .o_inm_ext     (o_inm_ext),
    .o_pc          (o_pc),
    .o_rs_addr     (o_rs_addr),
    .o_rt_addr     (o_rt_addr),
    .o_wr_addr     (o_wr_addr),
    .o_opcode      (o_opcode),
    .o_funct       (o_funct),
    .o_reg_write   (o_reg_write),
    .o_mem_read    (o_mem_read),
    .o_mem_write   (o_mem_write),
    .o_mem_to_reg  (o_mem_to_reg),
    .o_alu_src     (o_alu_src)
  );

  // 10-unit clock, posedge at 5, 15, ...
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // comb = {branch, jump_inm, jump_rs, stall}; ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src}
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wbWrite;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        exMemRead;
    logic [4:0]  exRt;
    logic [3:0]  expComb;
    logic [31:0] expRs;
    logic [31:0] expRt;
    logic [31:0] expInm;
    logic [31:0] expPc;
    logic [4:0]  expWr;
    logic [4:0]  expCtrl;
    logic        expNop;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mk(input string name, input logic [31:0] instr, input logic [31:0] pc,
                              input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                              input logic exr, input logic [4:0] exrt, input logic [3:0] comb,
                              input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] inm,
                              input logic [31:0] epc, input logic [4:0] wr, input logic [4:0] ctrl,
                              input logic nop);
    vec_t v;
    v.name = name; v.instr = instr; v.pc = pc;
    v.wbWrite = wbw; v.wbAddr = wba; v.wbData = wbd;
    v.exMemRead = exr; v.exRt = exrt; v.expComb = comb;
    v.expRs = rs; v.expRt = rt; v.expInm = inm; v.expPc = epc;
    v.expWr = wr; v.expCtrl = ctrl; v.expNop = nop;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_valid       = 1'b1;
    i_instruction = v.instr;
    i_pc          = v.pc;
    i_wb_write    = v.wbWrite;
    i_wb_addr     = v.wbAddr;
    i_wb_data     = v.wbData;
    i_ex_mem_read = v.exMemRead;
    i_ex_rt       = v.exRt;
  endtask

  task automatic checkRegistered(input string name, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [31:0] inm, input logic [31:0] pc, input logic [4:0] wr,
                                 input logic [4:0] ctrl, input logic nop);
    checkOutput({name, ".rs_data"}, o_rs_data, rs);
    checkOutput({name, ".rt_data"}, o_rt_data, rt);
    checkOutput({name, ".inm_ext"}, o_inm_ext, inm);
    checkOutput({name, ".pc"}, o_pc, pc);
    checkOutput({name, ".wr_addr"}, {27'd0, o_wr_addr}, {27'd0, wr});
    checkOutput({name, ".ctrl"}, {27'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src},
                {27'd0, ctrl});
    checkOutput({name, ".nop_reg"}, {31'd0, o_nop_reg}, {31'd0, nop});
  endtask

  task automatic clearInputs();
    i_valid       = 1'b0;
    i_instruction = '0;
    i_pc          = '0;
    i_wb_write    = 1'b0;
    i_wb_addr     = '0;
    i_wb_data     = '0;
    i_ex_mem_read = 1'b0;
    i_ex_rt       = '0;
  endtask

  initial begin
    vec_t v;
    // name, instr, pc, wbw, wba, wbd, exr, exrt, comb, rs, rt, inm, pc, wr, ctrl, nop
    vecs.push_back(mk("wb_r1", 32'h0, 32'h04, 1, 5'd1, 32'd7, 0, 5'd0, 4'b0000, 0, 0, 0, 32'h04, 5'd0, 5'b00000, 0));
    vecs.push_back(mk("wb_r2", 32'h0, 32'h08, 1, 5'd2, 32'd7, 0, 5'd0, 4'b0000, 0, 0, 0, 32'h08, 5'd0, 5'b00000, 0));
    vecs.push_back(mk("add_wt", rtype(5, 0, 3, 6'h20), 32'h0C, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 4'b0000,
                      32'hDEADBEEF, 0, 32'h1820, 32'h0C, 5'd3, 5'b10000, 0));
    vecs.push_back(mk("r0_write", rtype(0, 5, 7, 6'h20), 32'h10, 1, 5'd0, 32'h1234, 0, 5'd0, 4'b0000,
                      0, 32'hDEADBEEF, 32'h3820, 32'h10, 5'd7, 5'b10000, 0));
    vecs.push_back(mk("wb_r9", rtype(0, 0, 10, 6'h20), 32'h14, 1, 5'd9, 32'h200, 0, 5'd0, 4'b0000,
                      0, 0, 32'h5020, 32'h14, 5'd10, 5'b10000, 0));
    vecs.push_back(mk("beq_taken", itype(6'd4, 1, 2, 16'h4), 32'h18, 0, 5'd0, 0, 0, 5'd0, 4'b1000,
                      32'd7, 32'd7, 32'h4, 32'h18, 5'd0, 5'b00000, 1));
    vecs.push_back(mk("squash_bne", itype(6'd5, 1, 0, 16'h8), 32'h1C, 0, 5'd0, 0, 0, 5'd0, 4'b0000,
                      0, 0, 0, 0, 5'd0, 5'b00000, 0));
    vecs.push_back(mk("beq_wt_nt", itype(6'd4, 1, 2, 16'h4), 32'h20, 1, 5'd2, 32'd8, 0, 5'd0, 4'b0000,
                      32'd7, 32'd8, 32'h4, 32'h20, 5'd0, 5'b00000, 0));
    vecs.push_back(mk("load_use", rtype(4, 1, 6, 6'h20), 32'h24, 0, 5'd0, 0, 1, 5'd4, 4'b0001,
                      0, 0, 0, 0, 5'd0, 5'b00000, 0));
    vecs.push_back(mk("ex_rt_zero", rtype(4, 1, 6, 6'h20), 32'h28, 0, 5'd0, 0, 1, 5'd0, 4'b0000,
                      0, 32'd7, 32'h3020, 32'h28, 5'd6, 5'b10000, 0));
    vecs.push_back(mk("jal", {6'd3, 26'h0000100}, 32'h40, 0, 5'd0, 0, 0, 5'd0, 4'b0100,
                      0, 0, 32'h100, 32'h40, 5'd31, 5'b10000, 1));
    vecs.push_back(mk("squash_nop", 32'h0, 32'h44, 0, 5'd0, 0, 0, 5'd0, 4'b0000,
                      0, 0, 0, 0, 5'd0, 5'b00000, 0));
    vecs.push_back(mk("jr", rtype(9, 0, 0, 6'd8), 32'h48, 0, 5'd0, 0, 0, 5'd0, 4'b0010,
                      32'h200, 0, 32'h8, 32'h48, 5'd0, 5'b00000, 1));
    vecs.push_back(mk("squash_jr", 32'h0, 32'h4C, 0, 5'd0, 0, 0, 5'd0, 4'b0000,
                      0, 0, 0, 0, 5'd0, 5'b00000, 0));
    vecs.push_back(mk("lw", itype(6'd35, 1, 11, 16'hFFFC), 32'h50, 0, 5'd0, 0, 0, 5'd0, 4'b0000,
                      32'd7, 0, 32'hFFFFFFFC, 32'h50, 5'd11, 5'b11011, 0));
    vecs.push_back(mk("sw", itype(6'd43, 1, 2, 16'h8), 32'h54, 0, 5'd0, 0, 0, 5'd0, 4'b0000,
                      32'd7, 32'd8, 32'h8, 32'h54, 5'd0, 5'b00101, 0));
    vecs.push_back(mk("ori_zext", itype(6'd13, 1, 12, 16'h8000), 32'h58, 0, 5'd0, 0, 0, 5'd0, 4'b0000,
                      32'd7, 0, 32'h00008000, 32'h58, 5'd12, 5'b10001, 0));
    vecs.push_back(mk("addi_sext", itype(6'd8, 1, 13, 16'h8000), 32'h5C, 0, 5'd0, 0, 0, 5'd0, 4'b0000,
                      32'd7, 0, 32'hFFFF8000, 32'h5C, 5'd13, 5'b10001, 0));
    vecs.push_back(mk("undef_op", {6'h3F, 26'h0}, 32'h60, 0, 5'd0, 0, 0, 5'd0, 4'b0000,
                      0, 0, 0, 32'h60, 5'd0, 5'b00000, 0));
    vecs.push_back(mk("sw_rt_stall", itype(6'd43, 0, 2, 16'h0), 32'h64, 0, 5'd0, 0, 1, 5'd2, 4'b0001,
                      0, 0, 0, 0, 5'd0, 5'b00000, 0));
    vecs.push_back(mk("bne_taken", itype(6'd5, 1, 0, 16'h8), 32'h68, 0, 5'd0, 0, 0, 5'd0, 4'b1000,
                      32'd7, 0, 32'h8, 32'h68, 5'd0, 5'b00000, 1));
    vecs.push_back(mk("squash_add", rtype(5, 0, 3, 6'h20), 32'h6C, 0, 5'd0, 0, 0, 5'd0, 4'b0000,
                      0, 0, 0, 0, 5'd0, 5'b00000, 0));
    vecs.push_back(mk("addi_nostall", itype(6'd8, 0, 2, 16'h5), 32'h70, 0, 5'd0, 0, 1, 5'd2, 4'b0000,
                      0, 32'd8, 32'h5, 32'h70, 5'd2, 5'b10001, 0));

    // Reset values while reset is held.
    clearInputs();
    i_reset = 1'b1;
    @(negedge i_clock);
    checkRegistered("reset", 0, 0, 0, 0, 5'd0, 5'b00000, 0);
    @(negedge i_clock);
    i_reset = 1'b0;

    // Table-driven vectors.
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      applyStimulus(v);
      #4;
      checkOutput({v.name, ".redirect_stall"}, {28'd0, o_branch, o_jump_inm, o_jump_rs, o_stall},
                  {28'd0, v.expComb});
      checkOutput({v.name, ".inm_i"}, {16'd0, o_inm_i}, {16'd0, v.instr[15:0]});
      checkOutput({v.name, ".inm_j"}, {6'd0, o_inm_j}, {6'd0, v.instr[25:0]});
      if (v.expComb[1]) checkOutput({v.name, ".rs_jump"}, o_rs_jump, v.expRs);
      @(posedge i_clock);
      #1;
      checkRegistered(v.name, v.expRs, v.expRt, v.expInm, v.expPc, v.expWr, v.expCtrl, v.expNop);
      @(negedge i_clock);
    end

    // Hold with i_valid=0 for three cycles while a jump is presented.
    clearInputs();
    i_instruction = {6'd3, 26'h0000100};
    i_pc          = 32'h80;
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clock);
      #1;
      checkRegistered("hold", 0, 32'd8, 32'h5, 32'h70, 5'd2, 5'b10001, 0);
      @(negedge i_clock);
    end

    // Asynchronous reset in the middle of a load-use stall.
    i_valid       = 1'b1;
    i_instruction = rtype(4, 1, 6, 6'h20);
    i_pc          = 32'h84;
    i_ex_mem_read = 1'b1;
    i_ex_rt       = 5'd4;
    #2;
    checkOutput("mid_stall.stall", {31'd0, o_stall}, 32'd1);
    i_reset = 1'b1;
    #1;
    checkOutput("async_rst.stall", {31'd0, o_stall}, 32'd0);
    checkRegistered("async_rst", 0, 0, 0, 0, 5'd0, 5'b00000, 0);
    @(negedge i_clock);
    i_reset       = 1'b0;
    i_ex_mem_read = 1'b0;
    i_ex_rt       = '0;

    // Redirect sets the squash flag, then reset discards it asynchronously.
    i_instruction = itype(6'd4, 0, 0, 16'h4);
    i_pc          = 32'h88;
    #4;
    checkOutput("post_rst.branch", {31'd0, o_branch}, 32'd1);
    @(posedge i_clock);
    #1;
    checkOutput("redirect.nop_reg", {31'd0, o_nop_reg}, 32'd1);
    @(negedge i_clock);
    i_reset = 1'b1;
    #1;
    checkOutput("rst_squash.nop_reg", {31'd0, o_nop_reg}, 32'd0);
    @(negedge i_clock);
    i_reset = 1'b0;

    // First valid cycle after release decodes normally; r1 and r2 were cleared.
    i_instruction = itype(6'd4, 1, 2, 16'h4);
    i_pc          = 32'h8C;
    #4;
    checkOutput("after_rst.branch", {31'd0, o_branch}, 32'd1);
    @(posedge i_clock);
    #1;
    checkRegistered("after_rst", 0, 0, 32'h4, 32'h8C, 5'd0, 5'b00000, 1);
    @(negedge i_clock);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 Parameter NB_REG, default 32: data and PC width.
REQ-002 Parameter NB_INSTR, default 32: instruction width.
REQ-003 Parameter N_REGS, default 32: register-file depth; the address width is clogb2(N_REGS-1), which is 5.
REQ-004 Ports, in order (clock and reset first):
- i_clock  in  1  single clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  pipeline advance enable.
- i_instruction  in  32  from fetch; 0 is NOP.
- i_pc  in  32  PC+4 from fetch.
- i_wb_write  in  1  write-back enable.
- i_wb_addr  in  5  write-back register.
- i_wb_data  in  32  write-back value.
- i_ex_mem_read  in  1  the EX-stage instruction is a load.
- i_ex_rt  in  5  the EX-stage load destination.
- o_branch, o_jump_inm, o_jump_rs  out  1 each  combinational redirect to fetch.
- o_inm_i  out  16  equals instr[15:0].
- o_inm_j  out  26  equals instr[25:0].
- o_rs_jump  out  32  rs value for JR/JALR.
- o_nop_reg  out  1  registered; squashes the fetched instruction.
- o_stall  out  1  combinational load-use hold.
- ID/EX registered outputs:
  - o_rs_data, o_rt_data, o_inm_ext, o_pc  out  32 each.
  - o_rs_addr, o_rt_addr, o_wr_addr  out  5 each.
  - o_opcode, o_funct  out  6 each.
  - o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src  out  1 each.

Function
REQ-005 Fields SHALL be decoded as follows:
- opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
- o_inm_ext SHALL be instr[15:0] sign-extended, except ANDI, ORI and XORI, which are zero-extended.
REQ-006 Register file: 32x32; register 0 SHALL always read 0; the write SHALL occur on the posedge when i_wb_write=1 and i_wb_addr!=0.
REQ-007 Register-file reads SHALL be combinational with write-through: when i_wb_write=1 and i_wb_addr equals the read address (nonzero), the read returns i_wb_data in the same cycle.
REQ-008 Control decode SHALL be:
- R-type (opcode 0): reg_write=1 and wr_addr=rd, except JR.
- I-type ALU: alu_src=1, wr_addr=rt.
- LW, LB and LH: mem_read=1, mem_to_reg=1.
- SW, SB and SH: mem_write=1 and reg_write=0.
- JAL: wr_addr=31; JALR: wr_addr=rd.
- Undefined opcodes SHALL decode as NOP (all controls 0).
REQ-009 o_branch SHALL be 1 under either condition:
- BEQ (opcode 4) and rs_data==rt_data;
- BNE (opcode 5) and rs_data!=rt_data.
REQ-010 o_jump_inm SHALL be 1 for J (2) and JAL (3).
REQ-011 o_jump_rs SHALL be 1 for opcode 0 with funct 8 (JR) or 9 (JALR), and o_rs_jump SHALL equal rs_data.
REQ-012 At most one redirect output SHALL be high at a time; all three SHALL be 0 while o_stall=1 or i_nop_reg state (o_nop_reg) =1.
REQ-013 o_stall SHALL be 1 when all of the following hold:
- i_ex_mem_read=1;
- i_ex_rt!=0;
- i_ex_rt equals rs, or equals rt for an instruction that reads rt (R-type, BEQ/BNE, stores).
REQ-014 On a posedge with i_valid=1 and o_stall=0, the ID/EX outputs SHALL capture the decoded values.
REQ-015 On a posedge with i_valid=1 and o_stall=1, the ID/EX stage SHALL insert a bubble: all control outputs 0 and o_wr_addr=0; data fields are don't-care, and the bench checks 0.
REQ-016 On a posedge with i_valid=0, all registered outputs, including o_nop_reg, SHALL hold.
REQ-017 For JAL/JALR, o_pc SHALL carry i_pc, which EX uses as the link value; for other instructions it also carries i_pc.
REQ-018 o_nop_reg SHALL be set to 1 on a posedge with i_valid=1 and any redirect high; otherwise it SHALL be set to 0 on a posedge with i_valid=1.
REQ-019 While o_nop_reg=1 the current instruction SHALL be treated as NOP for control outputs, redirects and stall.
REQ-020 The branch compare SHALL use the write-through read values from REQ-007, so a same-cycle write-back is observed.

Reset
REQ-021 While i_reset=1, asynchronously:
- all registered outputs SHALL be 0;
- o_nop_reg SHALL be 0;
- all 32 registers SHALL be 0.
REQ-022 Reset asserted mid-stall or mid-redirect SHALL discard the pending bubble and the squash; the first valid cycle after release decodes i_instruction normally.

Structure
REQ-023 A shared package SHALL hold the opcode and funct constants (J, JAL, BEQ, BNE, LW, SW, ANDI, ORI, XORI, JR, JALR) and the link register index 31.
REQ-024 The register file SHALL be a sub-module named register_file with two read ports and one write port with write-through; decode, hazard and ID/EX logic live in instruction_decode.

Verification
REQ-025 Write-back with write-through:
- Stimulus: i_wb_write=1, i_wb_addr=5, i_wb_data=0xDEADBEEF, and i_instruction = ADD r3,r5,r0 in the same cycle.
- Response: o_rs_data=0xDEADBEEF and o_wr_addr=3 after the edge.
- Also check that a write to r0 reads back 0.
REQ-026 BEQ decision:
- BEQ r1,r2,+4 with r1=r2=7: o_branch=1 and o_inm_i=0x0004, and o_nop_reg=1 on the next cycle.
- With r2=8: o_branch=0.
REQ-027 Load-use stall:
- Stimulus: i_ex_mem_read=1, i_ex_rt=4, and i_instruction = ADD r6,r4,r1.
- Response: o_stall=1 and a bubble on the next edge.
- Repeat with i_ex_rt=0: o_stall=0.
REQ-028 Jumps:
- JAL 0x0000100 with i_pc=0x40: o_jump_inm=1, o_inm_j=0x0000100, o_wr_addr=31, o_pc=0x40.
- JR r9 (r9=0x200): o_jump_rs=1 and o_rs_jump=0x200.
REQ-029 Squash and reset:
- With o_nop_reg=1, present BNE taken: no redirect and zero controls.
- Assert i_reset mid-stall: all outputs become 0 immediately, without waiting for a clock edge.
- i_valid=0 for 3 cycles: outputs hold.
